bus_stream_fifo: RTL

Memory-mapped responder on the core's data bus that bridges CPU loads and stores to a pair of streaming FIFOs. CPU stores push 32-bit words into a TX FIFO, which drains through a valid/ready output stream. An input stream fills an RX FIFO, which CPU loads pop. Read data is combinational, so the single-cycle core completes a load in the same cycle. Pointer, count and flag updates occur on the rising clock edge.

---
 rtl/bus_stream_fifo.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/bus_stream_fifo.sv
// Memory-mapped bridge between a single-cycle CPU data bus and a pair of 32-bit stream FIFOs.
// Optional interrupt logic enabled by defining BUS_STREAM_FIFO_IRQ_EN.
module bus_stream_fifo #(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        busSel,
   input  logic        busWe,
   input  logic        busRe,
   input  logic [3:0]  busAddr,
   input  logic [31:0] busWData,
   input  logic [3:0]  Byte_Enable,
   output logic [31:0] busRData,
   output logic [31:0] tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [31:0] rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        irq
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int AW = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [31:0]   r_tx_mem [DEPTH];
   logic [31:0]   r_rx_mem [DEPTH];
   logic [AW-1:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
   logic [CW-1:0] r_tx_cnt, r_rx_cnt;
   logic          r_tx_ovf, r_rx_udf;

   logic w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
   logic w_tx_st, w_rx_ld, w_ctrl_wr;
   logic w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
   logic w_tx_flush, w_rx_flush, w_clr;
   logic [31:0] w_wmask, w_status, w_ctrl_rd;
   logic w_unused;

   assign w_tx_empty = (r_tx_cnt == '0);
   assign w_tx_full  = (r_tx_cnt == FULL_CNT);
   assign w_rx_empty = (r_rx_cnt == '0);
   assign w_rx_full  = (r_rx_cnt == FULL_CNT);

   assign w_tx_st   = busSel & busWe & (busAddr[3:2] == 2'b00);
   assign w_rx_ld   = busSel & busRe & (busAddr[3:2] == 2'b01);
   assign w_ctrl_wr = busSel & busWe & (busAddr[3:2] == 2'b11) & Byte_Enable[0];

   assign w_tx_flush = w_ctrl_wr & busWData[0];
   assign w_rx_flush = w_ctrl_wr & busWData[1];
   assign w_clr      = w_ctrl_wr & busWData[2];

   // A flush may coincide with a stream-side rx handshake; flush wins, so the word is discarded.
   assign w_tx_push = w_tx_st & ~w_tx_full;
   assign w_tx_pop  = ~w_tx_empty & tx_ready;
   assign w_rx_push = ~w_rx_full & rx_valid & ~w_rx_flush;
   assign w_rx_pop  = w_rx_ld & ~w_rx_empty;

   assign w_wmask = {{8{Byte_Enable[3]}}, {8{Byte_Enable[2]}},
                     {8{Byte_Enable[1]}}, {8{Byte_Enable[0]}}};

   assign tx_valid = ~w_tx_empty;
   assign tx_data  = r_tx_mem[r_tx_rp];
   assign rx_ready = ~w_rx_full;

   assign w_unused = &{1'b0, busAddr[1:0]};

   always_ff @(posedge clk) begin
      if (w_tx_push) r_tx_mem[r_tx_wp] <= busWData & w_wmask;
      if (w_rx_push) r_rx_mem[r_rx_wp] <= rx_data;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_tx_wp  <= '0;
         r_tx_rp  <= '0;
         r_tx_cnt <= '0;
      end else if (w_tx_flush) begin
         r_tx_wp  <= '0;
         r_tx_rp  <= '0;
         r_tx_cnt <= '0;
      end else begin
         if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
         if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
         if (w_tx_push && !w_tx_pop)      r_tx_cnt <= r_tx_cnt + 1'b1;
         else if (!w_tx_push && w_tx_pop) r_tx_cnt <= r_tx_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_rx_wp  <= '0;
         r_rx_rp  <= '0;
         r_rx_cnt <= '0;
      end else if (w_rx_flush) begin
         r_rx_wp  <= '0;
         r_rx_rp  <= '0;
         r_rx_cnt <= '0;
      end else begin
         if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
         if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
         if (w_rx_push && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + 1'b1;
         else if (!w_rx_push && w_rx_pop) r_rx_cnt <= r_rx_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset || w_clr) begin
         r_tx_ovf <= 1'b0;
         r_rx_udf <= 1'b0;
      end else begin
         if (w_tx_st && w_tx_full)  r_tx_ovf <= 1'b1;
         if (w_rx_ld && w_rx_empty) r_rx_udf <= 1'b1;
      end
   end

`ifdef BUS_STREAM_FIFO_IRQ_EN
   logic [1:0] r_mask;
   logic       r_irq;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_mask <= '0;
         r_irq  <= 1'b0;
      end else begin
         if (w_ctrl_wr) r_mask <= busWData[5:4];
         r_irq <= (r_mask[0] & ~w_rx_empty) | (r_mask[1] & ~w_tx_full);
      end
   end

   assign irq       = r_irq;
   assign w_ctrl_rd = {26'd0, r_mask, 4'd0};
`else
   assign irq       = 1'b0;
   assign w_ctrl_rd = '0;
`endif

   assign w_status = {8'd0, 8'(r_rx_cnt), 8'(r_tx_cnt), 2'b00, r_rx_udf, r_tx_ovf,
                      w_rx_full, w_rx_empty, w_tx_full, w_tx_empty};

   always_comb begin
      busRData = '0;
      if (busSel) begin
         case (busAddr[3:2])
            2'b01:   busRData = w_rx_empty ? '0 : r_rx_mem[r_rx_rp];
            2'b10:   busRData = w_status;
            2'b11:   busRData = w_ctrl_rd;
            default: busRData = '0;
         endcase
      end
   end

endmodule
